// File: rtl/image_mem_sequencer.sv
// image_mem_sequencer: read/write pointer pair and strobe scheduler for the
// raw-image read memory and the processed-image write memory.
// Optional feature: define IMG_SEQ_CONTINUOUS_EN to stream frame after frame
// without returning to DONE (done becomes a one-cycle pulse).
module image_mem_sequencer #(
  parameter int IMG_BYTES = 152100,
  parameter int STEP      = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One extra bit on the sums so the frame-boundary compare cannot overflow.
  localparam logic [ADDR_W:0] STEP_X  = (ADDR_W+1)'(STEP);
  localparam logic [ADDR_W:0] LIMIT_X = (ADDR_W+1)'(IMG_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_sum;
  logic [ADDR_W:0]   wr_sum;

  assign rd_sum = {1'b0, rd_ptr} + STEP_X;
  assign wr_sum = {1'b0, wr_ptr} + STEP_X;

  // Acceptance depends only on the state, never on the request inputs.
  assign stall = (state != RUN);
  assign busy  = (state == RUN);

  // Main FSM: pointer advance, registered strobes/addresses, frame accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      done      <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      rd_en    <= 1'b0;
      wr_en    <= 1'b0;
      rd_valid <= rd_en;
`ifdef IMG_SEQ_CONTINUOUS_EN
      done     <= 1'b0;
`endif
      if (start) begin
        state  <= RUN;
        rd_ptr <= '0;
        wr_ptr <= '0;
        done   <= 1'b0;
      end else if (state == RUN) begin
        if (rd_req) begin
          rd_en   <= 1'b1;
          rd_addr <= rd_ptr;
          if (rd_sum >= LIMIT_X) begin
            rd_ptr <= '0;
          end else begin
            rd_ptr <= rd_sum[ADDR_W-1:0];
          end
        end
        if (wr_req) begin
          wr_en   <= 1'b1;
          wr_addr <= wr_ptr;
          if (wr_sum == LIMIT_X) begin
            wr_ptr    <= '0;
            frame_cnt <= frame_cnt + 8'd1;
            done      <= 1'b1;
`ifndef IMG_SEQ_CONTINUOUS_EN
            state     <= DONE;
`endif
          end else begin
            wr_ptr <= wr_sum[ADDR_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_image_mem_sequencer.sv
// Scoreboard bench for image_mem_sequencer. Stimulus pushes expected strobe
// addresses into queues; a monitor pops and compares whenever a strobe appears.
module tb_image_mem_sequencer;

  localparam int IMG   = 152100;
  localparam int WORDS = IMG / 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rd_req, wr_req;
  logic        rd_en, rd_valid, wr_en, stall, busy, done;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];

  image_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_req(rd_req), .wr_req(wr_req),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .stall(stall), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic w);
    start  = s;
    rd_req = r;
    wr_req = w;
  endtask

  // Monitor: strobes consume queued expectations; rd_valid must follow a matched read.
  initial begin : monitor
    logic valid_due;
    logic matched;
    valid_due = 1'b0;
    forever begin
      @(negedge clk);
      matched = 1'b0;
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_rd_en: got rd_en=1 addr %0d required rd_en=0", rd_addr);
        end else begin
          checkOutput("rd_addr", rd_addr, rd_q.pop_front());
          matched = 1'b1;
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("[TB] FAIL unexpected_wr_en: got wr_en=1 addr %0d required wr_en=0", wr_addr);
        end else begin
          checkOutput("wr_addr", wr_addr, wr_q.pop_front());
        end
      end
      if (rd_valid || valid_due) checkOutput("rd_valid", rd_valid, valid_due);
      valid_due = matched && rst_n;
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"}, stall, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rd_en"}, rd_en, 0);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_rd_valid"}, rd_valid, 0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
    checkOutput({tag, "_rd_addr"}, rd_addr, 0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single reads after start: addresses 0 then 4, address held afterwards.
    applyStimulus(1, 0, 0); tick();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("run_busy", busy, 1);
    checkOutput("run_stall", stall, 0);
    tick();
    rd_q.push_back(0);
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick();
    rd_q.push_back(4);
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick(); tick();
    @(negedge clk);
    checkOutput("hold_rd_en", rd_en, 0);
    checkOutput("hold_rd_addr", rd_addr, 4);
    tick();

    // Simultaneous read and write for three cycles.
    applyStimulus(1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(i * 4);
      wr_q.push_back(i * 4);
      applyStimulus(0, 1, 1); tick();
    end
    applyStimulus(0, 0, 0); tick(); tick();

    // Full frame of writes; reads run one word ahead to hit the read wrap.
    applyStimulus(1, 0, 0); tick();
    rd_q.push_back(0);
    applyStimulus(0, 1, 0); tick();
    for (int i = 0; i < WORDS; i++) begin
      rd_q.push_back(((i + 1) * 4) % IMG);
      wr_q.push_back(i * 4);
      applyStimulus(0, 1, 1); tick();
    end
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("frame_last_wr_addr", wr_addr, 152096);
    checkOutput("frame_rd_wrap_addr", rd_addr, 0);
    checkOutput("frame_cnt_1", frame_cnt, 1);
    checkOutput("frame_done", done, 1);
`ifdef IMG_SEQ_CONTINUOUS_EN
    tick();
    @(negedge clk);
    checkOutput("cont_done_pulse", done, 0);
    checkOutput("cont_stall", stall, 0);
    wr_q.push_back(0);
    applyStimulus(0, 0, 1); tick();
    applyStimulus(0, 0, 0); tick(); tick();
`else
    checkOutput("frame_stall", stall, 1);
    checkOutput("frame_busy", busy, 0);
    tick();
    applyStimulus(0, 1, 1); tick(); tick();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("done_held", done, 1);
    checkOutput("done_stall_held", stall, 1);
    tick(); tick();
`endif

    // Start with a colliding read while rd_ptr=40: read dropped, pointer cleared.
    applyStimulus(1, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      rd_q.push_back(i * 4);
      applyStimulus(0, 1, 0); tick();
    end
    applyStimulus(1, 1, 0); tick();
    rd_q.push_back(0);
    applyStimulus(0, 1, 0); tick();
    applyStimulus(0, 0, 0); tick(); tick();
    @(negedge clk);
    checkOutput("start_keeps_frame_cnt", frame_cnt, 1);
    tick();

    // Asynchronous reset mid-frame with wr_ptr=100.
    applyStimulus(1, 0, 0); tick();
    for (int i = 0; i < 25; i++) begin
      wr_q.push_back(i * 4);
      applyStimulus(0, 0, 1); tick();
    end
    applyStimulus(0, 0, 0); tick(); tick();
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("async_reset");
    tick();
    rst_n = 1'b1;
    applyStimulus(0, 1, 1);
    repeat (4) tick();
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("post_reset_stall", stall, 1);
    tick();
    applyStimulus(1, 0, 0); tick();
    rd_q.push_back(0);
    wr_q.push_back(0);
    applyStimulus(0, 1, 1); tick();
    applyStimulus(0, 0, 0); tick(); tick(); tick();

    checkOutput("rd_queue_drained", rd_q.size(), 0);
    checkOutput("wr_queue_drained", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
